// File: rtl/chip8_memory_if.sv
// CPU memory port and host loader port of the CHIP-8 main memory.
// master = cpu/host side, slave = memory side.
interface chip8_memory_if #(
  parameter int ADDR_W = 12
);
  logic              mem_read;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [7:0]        mem_read_data;
  logic              mem_read_ack;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [7:0]        mem_write_data;
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              load_ready;

  modport master (
    output mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
           load_valid, load_addr, load_data,
    input  mem_read_data, mem_read_ack, load_ready
  );

  modport slave (
    input  mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
           load_valid, load_addr, load_data,
    output mem_read_data, mem_read_ack, load_ready
  );
endinterface

// File: rtl/chip8_memory.sv
// 4 KiB single-port CHIP-8 main memory: font init after reset, then cpu reads/writes and host loads.
// Read ack arrives two edges after the request; loader stalls behind init, cpu write and cpu read.
module chip8_memory #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] FONT_BASE = '0,
  parameter bit                INIT_FONT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  chip8_memory_if.slave bus,
  output logic          busy
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [7:0] FONT [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, HOLD = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [6:0]        init_cnt;
  logic              up;
  logic              rd_accept;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic [7:0]        rd_q;
  logic [7:0]        ram [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_accept) state_nxt = READ;
      READ:    state_nxt = HOLD;
      HOLD:    if (!bus.mem_read || bus.mem_read_addr != lat_addr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The RAM port is taken in the accept cycle itself, so the loader only gets leftover cycles.
  always_comb begin
    rd_accept      = up && !busy && !bus.mem_write && bus.mem_read && (state == IDLE);
    bus.load_ready = up && !busy && !bus.mem_write && !rd_accept;
  end

  always_comb begin
    we    = 1'b0;
    waddr = bus.load_addr;
    wdata = bus.load_data;
    if (busy) begin
      we    = 1'b1;
      waddr = FONT_BASE + ADDR_W'(init_cnt);
      wdata = FONT[init_cnt];
    end else if (up && bus.mem_write) begin
      we    = 1'b1;
      waddr = bus.mem_write_addr;
      wdata = bus.mem_write_data;
    end else if (bus.load_valid && bus.load_ready) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy              <= INIT_FONT;
      init_cnt          <= '0;
      up                <= 1'b0;
      lat_addr          <= '0;
      bus.mem_read_ack  <= 1'b0;
      bus.mem_read_data <= '0;
    end else begin
      up               <= 1'b1;
      bus.mem_read_ack <= (state == READ);
      if (state == READ) bus.mem_read_data <= rd_q;
      if (rd_accept)     lat_addr <= bus.mem_read_addr;
      if (busy) begin
        init_cnt <= init_cnt + 7'd1;
        if (init_cnt == 7'd79) busy <= 1'b0;
      end
    end
  end

  // No write can coincide with an accepted read, so rd_q never sees a stale byte.
  always_ff @(posedge clk) begin
    if (we)        ram[waddr] <= wdata;
    if (rd_accept) rd_q <= ram[bus.mem_read_addr];
  end

endmodule

// File: tb/tb_chip8_memory.sv
// Directed plus randomized bench for chip8_memory against a byte-array memory model.
module tb_chip8_memory;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  chip8_memory_if bus ();

  chip8_memory dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  model [4096];
  bit          known [4096];
  logic [11:0] known_q [$];

  logic [7:0] font [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mark(input logic [11:0] a, input logic [7:0] d);
    model[a] = d;
    if (!known[a]) begin
      known[a] = 1'b1;
      known_q.push_back(a);
    end
  endtask

  task automatic load_font_model();
    for (int i = 0; i < 80; i++) mark(12'(i), font[i]);
  endtask

  // Called at a negedge; returns at the negedge where ack is seen (or budget expires).
  task automatic wait_ack(input int budget, output bit got, output int lat);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_read_ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic cpu_read(input logic [11:0] a, input string tag);
    bit got;
    int lat;
    bus.mem_read      = 1'b1;
    bus.mem_read_addr = a;
    wait_ack(8, got, lat);
    check({tag, " ack"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'd2);
    check({tag, " data"}, 32'(bus.mem_read_data), 32'(model[a]));
    bus.mem_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    bus.mem_write      = 1'b1;
    bus.mem_write_addr = a;
    bus.mem_write_data = d;
    @(negedge clk);
    bus.mem_write = 1'b0;
  endtask

  // Leaves load_valid high so consecutive calls model a held valid.
  task automatic load_byte(input logic [11:0] a, input logic [7:0] d, input string tag);
    bit got;
    bit r;
    got            = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_addr  = a;
    bus.load_data  = d;
    for (int i = 0; i < 10; i++) begin
      #1 r = bus.load_ready;
      @(negedge clk);
      if (r) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, 32'(got), 32'd1);
    if (got) mark(a, d);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 10) check({tag, " load_ready while busy"}, 32'(bus.load_ready), 32'd0);
      @(negedge clk);
    end
    check({tag, " busy cycles"}, 32'(n), 32'd80);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    int          lat;
    int          acks;
    logic [11:0] a;
    logic [7:0]  d;

    bus.mem_read       = 1'b0;
    bus.mem_read_addr  = '0;
    bus.mem_write      = 1'b0;
    bus.mem_write_addr = '0;
    bus.mem_write_data = '0;
    bus.load_valid     = 1'b0;
    bus.load_addr      = '0;
    bus.load_data      = '0;

    repeat (3) @(negedge clk);
    check("reset ack", 32'(bus.mem_read_ack), 32'd0);
    check("reset data", 32'(bus.mem_read_data), 32'd0);
    check("reset load_ready", 32'(bus.load_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd1);

    rst_n = 1'b1;
    wait_init("init1");
    load_font_model();

    for (int i = 0; i < 5; i++) cpu_read(12'(i), $sformatf("font0[%0d]", i));
    for (int i = 'h4B; i <= 'h4F; i++) cpu_read(12'(i), $sformatf("fontF[%0h]", i));

    load_byte(12'h200, 8'h12, "load 0x200 ready");
    load_byte(12'h201, 8'h00, "load 0x201 ready");
    bus.load_valid = 1'b0;

    bus.mem_read      = 1'b1;
    bus.mem_read_addr = 12'h200;
    wait_ack(8, got, lat);
    check("rd200 ack", 32'(got), 32'd1);
    check("rd200 latency", 32'(lat), 32'd2);
    check("rd200 data", 32'(bus.mem_read_data), 32'h12);
    bus.mem_read_addr = 12'h201;
    wait_ack(8, got, lat);
    check("rd201 ack", 32'(got), 32'd1);
    check("rd201 latency", 32'(lat), 32'd3);
    check("rd201 data", 32'(bus.mem_read_data), 32'h00);
    bus.mem_read = 1'b0;
    @(negedge clk);

    bus.mem_read      = 1'b1;
    bus.mem_read_addr = 12'h300;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_read_ack) acks++;
    end
    check("held read ack count", 32'(acks), 32'd1);
    bus.mem_read = 1'b0;
    @(negedge clk);

    bus.mem_write      = 1'b1;
    bus.mem_write_addr = 12'h300;
    bus.mem_write_data = 8'hA5;
    bus.mem_read       = 1'b1;
    bus.mem_read_addr  = 12'h300;
    @(negedge clk);
    bus.mem_write = 1'b0;
    mark(12'h300, 8'hA5);
    wait_ack(8, got, lat);
    check("wr+rd ack", 32'(got), 32'd1);
    check("wr+rd latency", 32'(lat), 32'd2);
    check("wr+rd data", 32'(bus.mem_read_data), 32'hA5);
    bus.mem_read = 1'b0;
    @(negedge clk);

    bus.load_valid     = 1'b1;
    bus.load_addr      = 12'h210;
    bus.load_data      = 8'h77;
    bus.mem_write      = 1'b1;
    bus.mem_write_addr = 12'h211;
    bus.mem_write_data = 8'h55;
    #1 check("load vs write ready", 32'(bus.load_ready), 32'd0);
    @(negedge clk);
    bus.mem_write = 1'b0;
    mark(12'h211, 8'h55);
    #1 check("load after write ready", 32'(bus.load_ready), 32'd1);
    @(negedge clk);
    bus.load_valid = 1'b0;
    mark(12'h210, 8'h77);
    cpu_read(12'h210, "rd210");
    cpu_read(12'h211, "rd211");

    cpu_write(12'h250, 8'h11);
    mark(12'h250, 8'h11);

    repeat (60) begin
      case ($urandom_range(0, 2))
        0: begin
          a = 12'($urandom_range(0, 4095));
          d = 8'($urandom_range(0, 255));
          cpu_write(a, d);
          mark(a, d);
        end
        1: begin
          a = 12'($urandom_range(0, 4095));
          d = 8'($urandom_range(0, 255));
          load_byte(a, d, "rand load ready");
          bus.load_valid = 1'b0;
        end
        default: begin
          a = known_q[$urandom_range(0, known_q.size() - 1)];
          cpu_read(a, $sformatf("rand rd %03h", a));
        end
      endcase
    end

    mark(12'h04B, 8'hF0);
    cpu_write(12'h04B, 8'hF0);
    cpu_read(12'h04B, "pre-reset rd");
    rst_n = 1'b0;
    #1;
    check("reset2 data", 32'(bus.mem_read_data), 32'd0);
    check("reset2 busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        bus.mem_write      = 1'b1;
        bus.mem_write_addr = 12'h250;
        bus.mem_write_data = 8'h99;
      end
      if (i == 21) bus.mem_write = 1'b0;
      @(negedge clk);
    end
    check("busy at byte 40", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-init reset busy", 32'(busy), 32'd1);
    check("mid-init reset ack", 32'(bus.mem_read_ack), 32'd0);
    check("mid-init reset ready", 32'(bus.load_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init2");
    load_font_model();

    for (int i = 0; i < 80; i++) cpu_read(12'(i), $sformatf("font after reset[%0d]", i));
    cpu_read(12'h250, "rd250 after reset");
    cpu_read(12'h200, "rd200 after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
